demux_channel_sequencer: RTL
============================

Name: demux_channel_sequencer

Overview:
Upstream control stage for the 1-to-8 demultiplexer (demux_1_8). It generates that block's sel and i inputs.
- Walks a programmable set of channels (y0..y6), driving each one for a programmable dwell time.
- Returns i to 0 for exactly one cycle whenever sel changes.
- Supports one-shot or continuous looping, abort, and a done pulse for the controlling logic.

Parameters:
SEL_W, 3, width of sel; must match the demux select width
NUM_CH, 7, number of usable demux outputs (channel indices 0..NUM_CH-1)
DWELL_W, 16, width of the dwell-count input

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
start  input  1  begin a scan; sampled only in IDLE
abort  input  1  terminate the scan; sampled in SETUP/DRIVE
ch_mask  input  NUM_CH  enabled channels (bit n = channel n); latched on accepted start
dwell  input  DWELL_W  cycles i is held high per channel; latched on accepted start; 0 treated as 1
loop  input  1  1 = wrap to the lowest enabled channel after the highest; latched on accepted start
sel  output  SEL_W  registered channel select to the demux
i  output  1  registered data/enable to the demux
busy  output  1  high in SETUP and DRIVE
done  output  1  one-cycle pulse when a one-shot scan completes

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, sel=0, i=0, busy=0, done=0, latched config cleared.
  - Reset overrides all other inputs, including in the middle of a scan.
- All outputs are registered; no combinational paths from input to output.
- States: IDLE, SETUP, DRIVE, DONE.
- IDLE: i=0, busy=0; sel holds its last value.
  - On start=1, latch ch_mask, dwell and loop.
  - If the mask is nonzero: sel <= lowest enabled channel and go to SETUP.
  - If the mask is zero: go to DONE.
- SETUP (exactly 1 cycle): i=0, busy=1, then go to DRIVE.
- DRIVE (i=1, busy=1) lasts max(dwell,1) cycles. On the last DRIVE cycle:
  - If a higher enabled channel exists: sel <= that channel, go to SETUP.
  - Else if loop=1: sel <= lowest enabled channel, go to SETUP. This applies even when only one channel is enabled.
  - Else: go to DONE.
- DONE (1 cycle): done=1, i=0, busy=0, then go to IDLE.
- sel changes only on an edge that leaves i=0. i never rises in the same cycle sel changes.
- Latency:
  - start sampled at edge k gives SETUP in cycle k+1 and i=1 from cycle k+2.
  - Each channel costs dwell+1 cycles.
- abort=1 in SETUP or DRIVE: next state IDLE, i=0, busy=0, done stays 0. abort takes priority over all transitions. abort is ignored in IDLE and DONE.
- start while busy, or in DONE, is ignored.
- Changes to ch_mask, dwell or loop during a scan have no effect until the next accepted start.
- Dwell counter:
  - Loaded with max(dwell,1)-1 on entry to DRIVE and decremented each cycle.
  - The last DRIVE cycle is when the counter equals 0.
  - No arithmetic wrap is possible.
- Mask bits at or above NUM_CH do not exist. sel never exceeds NUM_CH-1.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, SETUP=2'd1, DRIVE=2'd2, DONE=2'd3)
  - defaults for NUM_CH and SEL_W, shared with demux_1_8
- One sub-module: next_ch_finder. Purely combinational.
  - Inputs: mask and current sel.
  - Outputs: next enabled index above sel, a found flag, and the lowest enabled index.

Test Plan:
1. rst_n=0 for 3 cycles with start=1 and ch_mask=7'h7F -> sel=0, i=0, busy=0, done=0 throughout; no scan starts after release unless start is sampled in IDLE.
2. ch_mask=7'h7F, dwell=3, loop=0, 1-cycle start -> sel steps 0..6. Each channel has 1 cycle i=0 then 3 cycles i=1. busy high for 28 cycles, done pulses once in cycle 29 after start.
3. ch_mask=7'b1010010, dwell=2 -> sel visits 1, 4, 6 only. 9 busy cycles, then done; channels 0, 2, 3, 5 are never selected while i=1.
4. ch_mask=0, start -> DONE the next cycle; done=1 for 1 cycle; busy and i never assert.
5. ch_mask=7'b0100100, dwell=1, loop=1 -> sel sequence 2, 5, 2, 5, ... with no done. abort during the 3rd DRIVE -> i=0 and busy=0 on the next edge, done stays 0.
6. dwell=0 -> each channel's i is high for exactly 1 cycle. Additional checks:
   - start re-pulsed mid-scan -> ignored.
   - rst_n low during DRIVE -> i=0 and sel=0 on the next edge.

Source files
------------

// File: rtl/demux_channel_sequencer_pkg.sv
// Shared definitions for the demux channel sequencer and the demux_1_8 it drives.
// Holds the FSM state encoding and the default channel/select geometry.
package demux_channel_sequencer_pkg;

    localparam int SEL_W_DEF   = 3;
    localparam int NUM_CH_DEF  = 7;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRIVE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/demux_channel_sequencer_next_ch_finder.sv
// Combinational search over the channel mask: the nearest enabled channel above
// the current select, and the lowest enabled channel overall.
module next_ch_finder
    import demux_channel_sequencer_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  next_idx,
    output logic              found,
    output logic [SEL_W-1:0]  low_idx
);

    // Scanning downwards lets the last hit win, which is the lowest qualifying index.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        low_idx  = '0;
        for (int n = NUM_CH - 1; n >= 0; n--) begin
            if (mask[n]) begin
                low_idx = SEL_W'(n);
                if (SEL_W'(n) > cur) begin
                    next_idx = SEL_W'(n);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/demux_channel_sequencer.sv
// Generates sel/i for demux_1_8: walks the enabled channels, holding i high for the
// dwell time on each, with a one-cycle i=0 gap around every select change.
module demux_channel_sequencer
    import demux_channel_sequencer_pkg::*;
#(
    parameter int SEL_W   = SEL_W_DEF,
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop,
    output logic [SEL_W-1:0]   sel,
    output logic               i,
    output logic               busy,
    output logic               done,
    output logic [1:0]         dbg_state
);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic               r_i;
    logic               r_busy;
    logic               r_done;
    logic [NUM_CH-1:0]  r_mask;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop;
    logic [DWELL_W-1:0] r_cnt;

    state_t             w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               w_latch;
    logic [NUM_CH-1:0]  w_mask;
    logic [SEL_W-1:0]   w_next_idx;
    logic               w_found;
    logic [SEL_W-1:0]   w_low_idx;

    // In IDLE the live mask is searched so the first channel is ready on the accepting edge.
    assign w_mask = (r_state == ST_IDLE) ? ch_mask : r_mask;

    next_ch_finder #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_finder (
        .mask     (w_mask),
        .cur      (r_sel),
        .next_idx (w_next_idx),
        .found    (w_found),
        .low_idx  (w_low_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_latch = 1'b1;
                    if (|ch_mask) begin
                        w_sel_nxt   = w_low_idx;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_SETUP: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = (r_dwell == '0) ? '0 : r_dwell - 1'b1;
                    w_state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == '0) begin
                    if (w_found) begin
                        w_sel_nxt   = w_next_idx;
                        w_state_nxt = ST_SETUP;
                    end else if (r_loop) begin
                        w_sel_nxt   = w_low_idx;
                        w_state_nxt = ST_SETUP;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers are loaded from the next state so they always agree with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_i     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_mask  <= '0;
            r_dwell <= '0;
            r_loop  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_i     <= (w_state_nxt == ST_DRIVE);
            r_busy  <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_DRIVE);
            r_done  <= (w_state_nxt == ST_DONE);
            if (w_latch) begin
                r_mask  <= ch_mask;
                r_dwell <= dwell;
                r_loop  <= loop;
            end
        end
    end

    assign sel       = r_sel;
    assign i         = r_i;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule
